// File: rtl/swerv_types.sv
// Shared types for the LSU debug trigger unit: trigger packets, LSU access
// packet, the extended trigger configuration and its compare-mode encodings.
package swerv_types;

    // Widest configuration the packed types carry; modules slice down to
    // their own XLEN / CNT_W parameters.
    localparam int TRIG_XLEN  = 64;
    localparam int TRIG_CNT_W = 12;

    typedef struct packed {
        logic                 select;   // 0: address, 1: data
        logic                 match;    // NAPOT enable when mode is NAPOT
        logic                 store;
        logic                 load;
        logic [TRIG_XLEN-1:0] tdata2;
    } trigger_pkt_t;

    typedef enum logic [1:0] {
        TRIG_EXACT = 2'd0,
        TRIG_NAPOT = 2'd1,
        TRIG_GE    = 2'd2,
        TRIG_LT    = 2'd3
    } trig_mode_e;

    typedef struct packed {
        trig_mode_e            mode;
        logic                  chain;   // meaningful on even indices only
        logic                  cnt_en;
        logic [TRIG_CNT_W-1:0] cnt;
    } lsu_trig_ext_t;

    // Access size: none of half/word/dword set means a byte access.
    typedef struct packed {
        logic valid;
        logic dma;
        logic load;
        logic store;
        logic half;
        logic word;
        logic dword;
    } lsu_pkt_t;

    // Mask keeping only the bytes actually written by a store of this size.
    function automatic logic [TRIG_XLEN-1:0] store_size_mask(input lsu_pkt_t pkt);
        logic [TRIG_XLEN-1:0] m;
        if (pkt.dword)     m = {TRIG_XLEN{1'b1}};
        else if (pkt.word) m = TRIG_XLEN'(64'h0000_0000_FFFF_FFFF);
        else if (pkt.half) m = TRIG_XLEN'(64'h0000_0000_0000_FFFF);
        else               m = TRIG_XLEN'(64'h0000_0000_0000_00FF);
        return m;
    endfunction

endpackage

// File: rtl/lsu_trig_cmp.sv
// Single-trigger comparator: picks the operand, applies the compare mode and
// qualifies the result with the access type. Purely combinational.
module lsu_trig_cmp
    import swerv_types::*;
#(
    parameter int XLEN = 64
) (
    input  trigger_pkt_t    trig,
    input  trig_mode_e      mode,
    input  logic            acc_load,
    input  logic            acc_store,
    input  logic            qual,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] sdata,
    output logic            hit
);

    logic [XLEN-1:0] tdata2;
    logic [XLEN-1:0] operand;
    logic [XLEN-1:0] napot_mask;
    logic            cmp_ok;
    logic            type_ok;

    // Operand select, mode compare and access-type qualification.
    always_comb begin
        tdata2  = trig.tdata2[XLEN-1:0];
        operand = trig.select ? sdata : addr;
        // x ^ (x+1) sets exactly the trailing ones plus the next bit above them.
        napot_mask = trig.match ? (tdata2 ^ (tdata2 + XLEN'(1))) : '0;
        case (mode)
            TRIG_EXACT: cmp_ok = (operand == tdata2);
            TRIG_NAPOT: cmp_ok = ((operand | napot_mask) == (tdata2 | napot_mask));
            TRIG_GE:    cmp_ok = (operand >= tdata2);
            TRIG_LT:    cmp_ok = (operand <  tdata2);
            default:    cmp_ok = 1'b0;
        endcase
        // Load-data triggers are not supported, so a data-select load never hits.
        type_ok = (trig.store & acc_store) | (trig.load & acc_load & ~trig.select);
        hit     = qual & type_ok & cmp_ok;
    end

endmodule

// File: rtl/lsu_trigger_unit.sv
// LSU data/address trigger unit at the dc3->dc4 boundary: per-trigger compare,
// pairwise chaining, hit counting, registered fire and sticky hit status.
module lsu_trigger_unit
    import swerv_types::*;
#(
    parameter int NUM_TRIG = 4,
    parameter int XLEN     = 64,
    parameter int CNT_W    = 12
) (
    input  logic                clk,
    input  logic                rst_l,
    input  trigger_pkt_t        trigger_pkt_any [NUM_TRIG],
    input  lsu_trig_ext_t       trig_ext_cfg    [NUM_TRIG],
    input  logic [NUM_TRIG-1:0] dec_trig_cfg_wr,
    input  logic [NUM_TRIG-1:0] dec_trig_status_clr,
    input  lsu_pkt_t            lsu_pkt_dc3,
    input  logic                lsu_flush_dc3,
    input  logic [XLEN-1:0]     lsu_addr_dc3,
    input  logic [XLEN-1:0]     store_data_dc3,
    output logic [NUM_TRIG-1:0] lsu_trigger_match_dc4,
    output logic [NUM_TRIG-1:0] lsu_trigger_hit_status
);

    logic                 qual;
    logic [TRIG_XLEN-1:0] size_mask;
    logic [XLEN-1:0]      sdata_masked;

    logic [NUM_TRIG-1:0]  raw_hit;
    logic [NUM_TRIG-1:0]  cnt_event;
    logic [NUM_TRIG-1:0]  own_fire;
    logic [NUM_TRIG-1:0]  match_d, match_q;
    logic [NUM_TRIG-1:0]  status_d, status_q;
    logic [CNT_W-1:0]     cnt_d [NUM_TRIG];
    logic [CNT_W-1:0]     cnt_q [NUM_TRIG];

    // Access qualification and size masking of store data, shared by all triggers.
    always_comb begin
        qual         = lsu_pkt_dc3.valid & ~lsu_pkt_dc3.dma & ~lsu_flush_dc3;
        size_mask    = store_size_mask(lsu_pkt_dc3);
        sdata_masked = store_data_dc3 & size_mask[XLEN-1:0];
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TRIG; gi++) begin : g_cmp
            lsu_trig_cmp #(.XLEN(XLEN)) u_cmp (
                .trig      (trigger_pkt_any[gi]),
                .mode      (trig_ext_cfg[gi].mode),
                .acc_load  (lsu_pkt_dc3.load),
                .acc_store (lsu_pkt_dc3.store),
                .qual      (qual),
                .addr      (lsu_addr_dc3),
                .sdata     (sdata_masked),
                .hit       (raw_hit[gi])
            );
        end
    endgenerate

    // Chaining: a chained pair counts on the even counter only, odd counter idles.
    always_comb begin
        cnt_event = raw_hit;
        for (int p = 0; p < NUM_TRIG / 2; p++) begin
            if (trig_ext_cfg[2*p].chain) begin
                cnt_event[2*p]   = raw_hit[2*p] & raw_hit[2*p+1];
                cnt_event[2*p+1] = 1'b0;
            end
        end
    end

    // Hit counters: fire when counting is off or the count has run down to 1 (or 0).
    always_comb begin
        for (int i = 0; i < NUM_TRIG; i++) begin
            cnt_d[i]    = cnt_q[i];
            own_fire[i] = 1'b0;
            if (cnt_event[i]) begin
                if (!trig_ext_cfg[i].cnt_en) begin
                    own_fire[i] = 1'b1;
                end else if (cnt_q[i] > CNT_W'(1)) begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end else begin
                    own_fire[i] = 1'b1;
                    cnt_d[i]    = trig_ext_cfg[i].cnt[CNT_W-1:0];
                end
            end
            // A config write overrides any same-cycle decrement or reload.
            if (dec_trig_cfg_wr[i]) begin
                cnt_d[i] = trig_ext_cfg[i].cnt[CNT_W-1:0];
            end
        end
    end

    // Fire fan-out (chained pairs report on both bits) and sticky status update.
    always_comb begin
        match_d = own_fire;
        for (int p = 0; p < NUM_TRIG / 2; p++) begin
            if (trig_ext_cfg[2*p].chain) begin
                match_d[2*p+1] = own_fire[2*p];
            end
        end
        status_d = match_d | (status_q & ~dec_trig_status_clr);
    end

    // dc4 pipeline register, status bits and hit counters.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            match_q  <= '0;
            status_q <= '0;
            cnt_q    <= '{default: '0};
        end else begin
            match_q  <= match_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
        end
    end

    assign lsu_trigger_match_dc4  = match_q;
    assign lsu_trigger_hit_status = status_q;

endmodule
